snn_input_ctrl: RTL and testbench
=================================

// Module: snn_input_ctrl
// PURPOSE
// - Sequencer in front of snn_core: receives a 784-pixel binary image as a byte stream and unpacks it into the 1-bit input RAM.
// - Then pulses core start, waits for core done, and returns the classified digit as one ASCII byte on a transmit handshake.
// - Owns the input-RAM address port: muxes it between its own writer and the core's read address (addr_input_unit).
// PARAMETERS
// - NUM_INPUTS  784  number of 1-bit input units (28x28 image)
// - ADDR_W      10   input-RAM address width; must satisfy 2**ADDR_W >= NUM_INPUTS
// - NUM_BYTES   98   NUM_INPUTS/8; localparam, not overridable
// PORTS
// - clk          in   1       system clock, all state on rising edge
// - rst_n        in   1       asynchronous active-low reset
// - rx_rdy       in   1       1-cycle pulse, rx_data valid
// - rx_data      in   8       received pixel byte; bit j of byte k = pixel 8k+j
// - ram_addr     out  ADDR_W  input-RAM address (writer or core_addr)
// - ram_we       out  1       input-RAM write enable
// - ram_wdata    out  1       input-RAM write data
// - core_addr    in   ADDR_W  snn_core addr_input_unit
// - core_start   out  1       1-cycle start pulse to snn_core
// - core_done    in   1       snn_core done (level or pulse; sampled in WAIT only)
// - core_digit   in   4       snn_core digit, valid when core_done=1
// - tx_start     out  1       1-cycle pulse, tx_data valid
// - tx_data      out  8       8'h30 + core_digit (ASCII)
// - tx_busy      in   1       transmitter busy; no tx_start while high
// - busy         out  1       high in any state except IDLE
// - overrun      out  1       sticky: byte dropped while unpacking; cleared by reset only
// BEHAVIOUR
// - Reset: state=IDLE, byte_cnt=0, bit_cnt=0, shift reg=0.
//   All outputs 0 at reset (tx_data=8'h30, ram_addr=core_addr).
// - States: IDLE, UNPACK, START, WAIT, SEND.
//   IDLE: rx_rdy -> latch rx_data into 8-bit shift reg, bit_cnt=0 -> UNPACK.
//   UNPACK: 8 cycles, ram_we=1, ram_addr=8*byte_cnt+bit_cnt, ram_wdata=shift[bit_cnt].
//     After bit 7: byte_cnt++.
//     If byte_cnt reaches NUM_BYTES: byte_cnt=0 -> START; else -> IDLE (await next byte).
//   START: core_start=1 for exactly one cycle -> WAIT.
//   WAIT: ram_addr=core_addr, ram_we=0.
//     core_done=1 -> capture tx_data=8'h30+core_digit -> SEND.
//   SEND: when tx_busy=0 assert tx_start one cycle -> IDLE; while tx_busy=1 hold in SEND.
// - busy=1 in UNPACK, START, WAIT, SEND; also in IDLE when byte_cnt!=0 (mid-image).
// - rx_rdy in UNPACK: byte dropped, overrun<=1.
//   rx_rdy in START/WAIT/SEND: ignored, no overrun.
//   rx_rdy in IDLE while clearing a previous image: accepted.
// - rx_rdy coincident with last UNPACK cycle: dropped (counts as UNPACK).
// - ram_addr mux: writer address only while ram_we=1; core_addr combinationally otherwise.
// - Write address arithmetic is ADDR_W wide; max written address = NUM_INPUTS-1 = 783, never wraps.
// - Latencies:
//   - last rx_rdy -> core_start: 9 cycles (8 UNPACK + START entry).
//   - core_done -> tx_start: 2 cycles when tx_busy=0.
// - Reset asserted mid-operation: aborts immediately to IDLE, partial image discarded (byte_cnt=0).
//   RAM contents undefined until a full image is reloaded.
// STRUCTURE
// - Package snn_pkg: NUM_INPUTS, ADDR_W, state enum snn_ctrl_state_t, ASCII_ZERO=8'h30.
// - One sub-module: snn_bit_unpacker (shift reg + bit_cnt + write-address gen); FSM stays in top.
// TESTING
// - 98 bytes of 8'hA5 spaced 20 cycles -> RAM[8k+0]=1, RAM[8k+1]=0, RAM[8k+7]=1 for all k; one core_start 9 cycles after last rx_rdy.
// - Full 98-byte image of sample_0, core model returns digit=7 -> tx_data=8'h37, tx_start one cycle, busy drops next cycle.
// - tx_busy held high 50 cycles after done -> no tx_start until tx_busy falls, then exactly one pulse.
// - Second rx_rdy 3 cycles after the first -> overrun=1, byte_cnt advances by 1 only, first byte's bits correct.
// - rst_n low during WAIT of image 1 -> IDLE, no tx_start; reload full image -> normal result.
// - rx_rdy pulses during WAIT/SEND -> ignored, overrun stays 0, next image starts at address 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and controller state encoding for the SNN input sequencer.
package snn_pkg;

  localparam int         NUM_INPUTS    = 784;
  localparam int         ADDR_W        = 10;
  localparam int         BITS_PER_BYTE = 8;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SEND   = 3'd4
  } snn_ctrl_state_t;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/snn_bit_unpacker.sv
// Holds the current pixel byte and walks it bit by bit, producing the
// input-RAM write address 8*byte_cnt + bit_cnt and the pixel value.
module snn_bit_unpacker #(
  parameter int ADDR_W    = 10,
  parameter int NUM_BYTES = 98
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [7:0]        data_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              wr_bit_o,
  output logic              last_bit_o,
  output logic              last_byte_o,
  output logic              mid_image_o
);
  import snn_pkg::*;

  localparam int BYTE_W = $clog2(NUM_BYTES);

  logic [BITS_PER_BYTE-1:0] shift_q, shift_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]        byte_cnt_q, byte_cnt_d;

  assign last_bit_o  = (bit_cnt_q == 3'd7);
  assign last_byte_o = (byte_cnt_q == BYTE_W'(NUM_BYTES - 1));
  assign mid_image_o = (byte_cnt_q != '0);
  assign wr_bit_o    = shift_q[bit_cnt_q];
  assign wr_addr_o   = ADDR_W'({byte_cnt_q, 3'b000}) | ADDR_W'(bit_cnt_q);

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (load_i) begin
      shift_d   = data_i;
      bit_cnt_d = '0;
    end else if (step_i) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      // The byte counter wraps to zero once the whole image has been written.
      if (last_bit_o) begin
        byte_cnt_d = last_byte_o ? '0 : byte_cnt_q + BYTE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/snn_input_ctrl.sv
// Sequencer in front of snn_core: unpacks a received image into the 1-bit
// input RAM, starts the core, and transmits the classified digit as ASCII.
module snn_input_ctrl #(
  parameter int NUM_INPUTS = snn_pkg::NUM_INPUTS,
  parameter int ADDR_W     = snn_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_wdata,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              overrun
);
  import snn_pkg::*;

  localparam int NUM_BYTES = NUM_INPUTS / BITS_PER_BYTE;

  snn_ctrl_state_t   state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              overrun_q, overrun_d;

  logic              load, step;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bit, last_bit, last_byte, mid_image;

  snn_bit_unpacker #(
    .ADDR_W    (ADDR_W),
    .NUM_BYTES (NUM_BYTES)
  ) u_unpacker (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (load),
    .data_i      (rx_data),
    .step_i      (step),
    .wr_addr_o   (wr_addr),
    .wr_bit_o    (wr_bit),
    .last_bit_o  (last_bit),
    .last_byte_o (last_byte),
    .mid_image_o (mid_image)
  );

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    // A byte arriving while the previous one is still being written is lost.
    overrun_d  = overrun_q | (rx_rdy && (state_q == ST_UNPACK));
    case (state_q)
      ST_IDLE: begin
        if (rx_rdy) begin
          load    = 1'b1;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        step = 1'b1;
        if (last_bit) begin
          state_d = last_byte ? ST_START : ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          tx_data_d = digit_to_ascii(core_digit);
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        // The pulse is registered; SEND is left only once it has been shown.
        if (tx_start_q) begin
          state_d = ST_IDLE;
        end else if (!tx_busy) begin
          tx_start_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= ASCII_ZERO;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ram_we     = (state_q == ST_UNPACK);
  assign ram_wdata  = ram_we & wr_bit;
  assign ram_addr   = ram_we ? wr_addr : core_addr;
  assign core_start = (state_q == ST_START);
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE) || mid_image;

endmodule

// File: tb/tb_snn_input_ctrl.sv
// Self-checking bench for snn_input_ctrl: RAM image, start/transmit timing,
// overrun handling and reset abort, against a pixel-level reference.
module tb_snn_input_ctrl;
  localparam int NI = 784;
  localparam int AW = 10;
  localparam int NB = 98;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [AW-1:0] ram_addr;
  logic          ram_we, ram_wdata;
  logic [AW-1:0] core_addr = '0;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [3:0]    core_digit = 4'h0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;
  logic          busy, overrun;

  snn_input_ctrl #(.NUM_INPUTS(NI), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .core_addr(core_addr), .core_start(core_start), .core_done(core_done),
    .core_digit(core_digit), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural RAM plus event log, sampled on the falling edge.
  int         cyc = 0;
  logic       mem [0:1023];
  int         wr_log[$];
  int         start_cnt = 0, start_cyc = 0, rx_cyc = 0, done_cyc = 0;
  int         tx_cnt = 0, tx_cyc = 0;
  logic [7:0] tx_val = 8'h00;
  logic       busy_at_tx = 1'b0, busy_after_tx = 1'b1, tx_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_log.push_back(int'(ram_addr));
    end
    if (rx_rdy) rx_cyc <= cyc;
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (core_done) done_cyc <= cyc;
    if (tx_start) begin
      tx_cnt     <= tx_cnt + 1;
      tx_cyc     <= cyc;
      tx_val     <= tx_data;
      busy_at_tx <= busy;
    end
    tx_prev <= tx_start;
    if (tx_prev) busy_after_tx <= busy;
  end

  typedef struct {
    bit         use_sample;
    logic [3:0] digit;
    int         done_delay;
    int         busy_hold;
    bit         noise;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t       tbl [4];
  logic [7:0] img [NB];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] mem_byte(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = mem[8*k + j];
    return b;
  endfunction

  // Synthetic "7": a top bar and a slanted stroke on the 28x28 grid.
  task automatic build_sample();
    for (int k = 0; k < NB; k++) img[k] = 8'h00;
    for (int p = 0; p < NI; p++) begin
      int r, c, w;
      bit on;
      r = p / 28;
      c = p % 28;
      w = 22 - ((r - 7) * 10) / 17;
      on = (r >= 4 && r <= 6 && c >= 5 && c <= 22) ||
           (r >= 7 && r <= 24 && c >= w - 1 && c <= w + 1);
      if (on) img[p/8][p%8] = 1'b1;
    end
  endtask

  task automatic build_random();
    for (int k = 0; k < NB; k++) img[k] = 8'($urandom);
  endtask

  task automatic send_image(input int gap);
    for (int k = 0; k < NB; k++) begin
      send_byte(img[k]);
      repeat (gap - 2 + int'($urandom_range(0, 2))) tick();
    end
  endtask

  task automatic check_ram(input string nm, input int w0);
    int mism;
    mism = 0;
    for (int i = 0; i < NI; i++)
      if (mem[i] !== img[i/8][i%8]) mism++;
    chk({nm, "_ram_bits"}, mism, 0);
    chk({nm, "_write_count"}, wr_log.size() - w0, NI);
    mism = 0;
    for (int i = 0; i < NI && w0 + i < wr_log.size(); i++)
      if (wr_log[w0 + i] != i) mism++;
    chk({nm, "_write_order"}, mism, 0);
  endtask

  task automatic run_image(input string nm, input int gap, input logic [3:0] digit,
                           input int done_delay, input int busy_hold, input bit noise,
                           input logic [7:0] exp_tx);
    int w0, s0, t0;
    w0 = wr_log.size();
    s0 = start_cnt;
    t0 = tx_cnt;
    send_image(gap);
    for (int i = 0; i < 300 && start_cnt == s0; i++) tick();
    chk({nm, "_start_count"}, start_cnt - s0, 1);
    chk({nm, "_start_latency"}, start_cyc - rx_cyc, 9);
    check_ram(nm, w0);
    core_addr = AW'($urandom);
    #2;
    chk({nm, "_wait_ram_addr"}, ram_addr, core_addr);
    chk({nm, "_wait_ram_we"}, ram_we, 0);
    if (noise) begin
      tick(); rx_rdy = 1'b1; rx_data = 8'($urandom);
      tick(); rx_rdy = 1'b0;
    end
    repeat (done_delay) tick();
    tx_busy = (busy_hold > 0);
    tick();
    core_done = 1'b1; core_digit = digit;
    tick();
    core_done = 1'b0; core_digit = 4'($urandom);
    if (busy_hold > 0) begin
      repeat (busy_hold) tick();
      if (noise) begin
        rx_rdy = 1'b1; rx_data = 8'($urandom);
        tick(); rx_rdy = 1'b0;
      end
      chk({nm, "_no_tx_while_busy"}, tx_cnt - t0, 0);
      tx_busy = 1'b0;
    end
    for (int i = 0; i < 50 && tx_cnt == t0; i++) tick();
    chk({nm, "_tx_seen"}, tx_cnt - t0, 1);
    if (busy_hold == 0) chk({nm, "_tx_latency"}, tx_cyc - done_cyc, 2);
    chk({nm, "_tx_data"}, tx_val, exp_tx);
    chk({nm, "_busy_at_tx"}, busy_at_tx, 1);
    repeat (5) tick();
    chk({nm, "_busy_after_tx"}, busy_after_tx, 0);
    chk({nm, "_tx_single"}, tx_cnt - t0, 1);
    chk({nm, "_overrun"}, overrun, 0);
    chk({nm, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int w0, s0, t0;

    tbl[0] = '{1'b1, 4'd7, 0, 0,  1'b0, 8'h37};
    tbl[1] = '{1'b0, 4'd0, 3, 0,  1'b1, 8'h30};
    tbl[2] = '{1'b0, 4'd9, 0, 50, 1'b1, 8'h39};
    tbl[3] = '{1'b0, 4'd4, 1, 5,  1'b0, 8'h34};

    // Reset state
    core_addr = 10'h155;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_tx_data", tx_data, 8'h30);
    chk("rst_ram_addr", ram_addr, 10'h155);
    rst_n = 1'b1;
    tick();

    // All-0xA5 image spaced 20 cycles
    for (int k = 0; k < NB; k++) img[k] = 8'hA5;
    run_image("a5", 20, 4'd2, 0, 0, 1'b0, 8'h32);
    chk("a5_bit0_k0", mem[0], 1);
    chk("a5_bit1_k50", mem[8*50 + 1], 0);
    chk("a5_bit7_k97", mem[8*97 + 7], 1);

    // Table-driven full images
    for (int t = 0; t < 4; t++) begin
      if (tbl[t].use_sample) build_sample(); else build_random();
      run_image($sformatf("tbl%0d", t), 10, tbl[t].digit, tbl[t].done_delay,
                tbl[t].busy_hold, tbl[t].noise, tbl[t].exp_tx);
    end

    // Second byte 3 cycles after the first is dropped
    do_reset();
    w0 = wr_log.size();
    send_byte(8'h3C);
    repeat (2) tick();
    rx_rdy = 1'b1; rx_data = 8'hC3;
    tick(); rx_rdy = 1'b0;
    repeat (10) tick();
    chk("ovr_flag", overrun, 1);
    chk("ovr_mid_image_busy", busy, 1);
    chk("ovr_writes_one_byte", wr_log.size() - w0, 8);
    send_byte(8'h96);
    repeat (12) tick();
    chk("ovr_writes_two_bytes", wr_log.size() - w0, 16);
    chk("ovr_byte0", mem_byte(0), 8'h3C);
    chk("ovr_byte1", mem_byte(1), 8'h96);
    chk("ovr_byte1_addr", wr_log[w0 + 8], 8);
    chk("ovr_sticky", overrun, 1);

    // Byte coincident with the last unpack cycle is dropped
    do_reset();
    chk("ovr_cleared_by_reset", overrun, 0);
    w0 = wr_log.size();
    send_byte(8'h5A);
    repeat (7) tick();
    rx_rdy = 1'b1; rx_data = 8'hFF;
    tick(); rx_rdy = 1'b0;
    repeat (5) tick();
    chk("last_cyc_overrun", overrun, 1);
    send_byte(8'h81);
    repeat (12) tick();
    chk("last_cyc_writes", wr_log.size() - w0, 16);
    chk("last_cyc_byte0", mem_byte(0), 8'h5A);
    chk("last_cyc_byte1", mem_byte(1), 8'h81);

    // Reset during WAIT aborts the image
    do_reset();
    build_random();
    s0 = start_cnt;
    t0 = tx_cnt;
    send_image(10);
    for (int i = 0; i < 300 && start_cnt == s0; i++) tick();
    chk("abort_reached_wait", start_cnt - s0, 1);
    rst_n = 1'b0;
    #2;
    chk("abort_busy", busy, 0);
    chk("abort_tx_data", tx_data, 8'h30);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    core_done = 1'b1; core_digit = 4'd5;
    tick(); core_done = 1'b0;
    repeat (60) tick();
    chk("abort_no_tx", tx_cnt - t0, 0);
    chk("abort_no_restart", start_cnt - s0, 1);
    chk("abort_idle", busy, 0);
    build_random();
    run_image("reload", 10, 4'd6, 2, 0, 1'b0, 8'h36);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
